// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter for 16 bus masters: holds each grant until done, request
// drop or hold timeout, with one turnaround cycle between owners.
module bus_arbiter_rr #(
  parameter int unsigned TW      = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        done,
  output logic [3:0]  gnt_idx,
  output logic        gnt_valid,
  output logic        timeout,
  output logic        busy
);

  localparam int unsigned NM = 16;
  localparam int unsigned IW = 4;
  localparam logic [TW-1:0] CNT_MAX  = '1;
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 32'd1);
  localparam bit            TO_EN    = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e        state_q;
  logic [IW-1:0] last_q;
  logic [IW-1:0] gnt_idx_q;
  logic          gnt_valid_q;
  logic          timeout_q;
  logic [TW-1:0] cnt_q;

  logic [IW-1:0] gnt_idx_d;
  logic          grant_d;
  logic          rel_done_c;
  logic          rel_drop_c;
  logic          rel_to_c;

  // First set request bit at or after last+1, wrapping past 15.
  always_comb begin
    logic [IW-1:0] cand;
    gnt_idx_d = '0;
    grant_d   = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NM; k++) begin
      cand = last_q + IW'(k);
      if (!grant_d && req[cand]) begin
        grant_d   = 1'b1;
        gnt_idx_d = cand;
      end
    end
  end

  always_comb begin
    rel_done_c = done;
    rel_drop_c = !req[gnt_idx_q];
    rel_to_c   = TO_EN && (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= IW'(NM - 1);
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE, GAP: begin
          if (grant_d) begin
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= OWN;
          end else begin
            state_q <= IDLE;
          end
        end
        OWN: begin
          // Saturating hold counter; freezes at max when the timeout is disabled.
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + TW'(1);
          if (rel_done_c || rel_drop_c || rel_to_c) begin
            gnt_valid_q <= 1'b0;
            last_q      <= gnt_idx_q;
            state_q     <= GAP;
            timeout_q   <= rel_to_c && !rel_done_c && !rel_drop_c;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed vector bench for bus_arbiter_rr built with TIMEOUT = 4.
module tb_bus_arbiter_rr;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        done;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic        timeout;
  logic        busy;

  int checks;
  int failures;

  bus_arbiter_rr #(.TW(8), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] req;
    logic        done;
    logic [3:0]  idx;
    logic        valid;
    logic        to;
    logic        busy;
  } vec_t;

  vec_t vecs[38];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] e_idx, input logic e_v,
                     input logic e_to, input logic e_busy);
    checks += 4;
    if (gnt_idx !== e_idx) begin
      failures++;
      $display("FAIL %s gnt_idx got=%0d want=%0d", name, gnt_idx, e_idx);
    end
    if (gnt_valid !== e_v) begin
      failures++;
      $display("FAIL %s gnt_valid got=%0b want=%0b", name, gnt_valid, e_v);
    end
    if (timeout !== e_to) begin
      failures++;
      $display("FAIL %s timeout got=%0b want=%0b", name, timeout, e_to);
    end
    if (busy !== e_busy) begin
      failures++;
      $display("FAIL %s busy got=%0b want=%0b", name, busy, e_busy);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [15:0] q, input logic d,
                              input logic [3:0] i, input logic v, input logic t,
                              input logic b);
    vec_t x;
    x.rst = r; x.req = q; x.done = d; x.idx = i; x.valid = v; x.to = t; x.busy = b;
    return x;
  endfunction

  initial begin
    checks   = 0;
    failures = 0;
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;

    // Reset, then 0/15 wrap-around alternation with done in the 2nd OWN cycle.
    vecs[0]  = mk(1, 16'h0000, 0, 4'd0,  0, 0, 0);
    vecs[1]  = mk(0, 16'h8001, 0, 4'd0,  1, 0, 1);
    vecs[2]  = mk(0, 16'h8001, 0, 4'd0,  1, 0, 1);
    vecs[3]  = mk(0, 16'h8001, 1, 4'd0,  0, 0, 1);
    vecs[4]  = mk(0, 16'h8001, 0, 4'd15, 1, 0, 1);
    vecs[5]  = mk(0, 16'h8001, 0, 4'd15, 1, 0, 1);
    vecs[6]  = mk(0, 16'h8001, 1, 4'd15, 0, 0, 1);
    vecs[7]  = mk(0, 16'h8001, 0, 4'd0,  1, 0, 1);
    vecs[8]  = mk(0, 16'h8001, 0, 4'd0,  1, 0, 1);
    vecs[9]  = mk(0, 16'h8001, 1, 4'd0,  0, 0, 1);
    vecs[10] = mk(0, 16'h8001, 0, 4'd15, 1, 0, 1);
    vecs[11] = mk(0, 16'h8001, 0, 4'd15, 1, 0, 1);
    vecs[12] = mk(0, 16'h8001, 1, 4'd15, 0, 0, 1);
    vecs[13] = mk(0, 16'h0000, 0, 4'd15, 0, 0, 0);
    // Timeout: master 4 owns four cycles, pulse in GAP, then master 5.
    vecs[14] = mk(0, 16'h0030, 0, 4'd4,  1, 0, 1);
    vecs[15] = mk(0, 16'h0030, 0, 4'd4,  1, 0, 1);
    vecs[16] = mk(0, 16'h0030, 0, 4'd4,  1, 0, 1);
    vecs[17] = mk(0, 16'h0030, 0, 4'd4,  1, 0, 1);
    vecs[18] = mk(0, 16'h0030, 0, 4'd4,  0, 1, 1);
    vecs[19] = mk(0, 16'h0030, 0, 4'd5,  1, 0, 1);
    // done coincides with the timeout cycle: release without a pulse.
    vecs[20] = mk(0, 16'h0030, 0, 4'd5,  1, 0, 1);
    vecs[21] = mk(0, 16'h0030, 0, 4'd5,  1, 0, 1);
    vecs[22] = mk(0, 16'h0030, 0, 4'd5,  1, 0, 1);
    vecs[23] = mk(0, 16'h0030, 1, 4'd5,  0, 0, 1);
    vecs[24] = mk(0, 16'h0000, 0, 4'd5,  0, 0, 0);
    // Request drop after two OWN cycles: GAP then IDLE.
    vecs[25] = mk(0, 16'h0008, 0, 4'd3,  1, 0, 1);
    vecs[26] = mk(0, 16'h0008, 0, 4'd3,  1, 0, 1);
    vecs[27] = mk(0, 16'h0000, 0, 4'd3,  0, 0, 1);
    vecs[28] = mk(0, 16'h0000, 0, 4'd3,  0, 0, 0);
    // Reset while master 9 owns; pointer back to 15 so 2 beats 4.
    vecs[29] = mk(0, 16'h0200, 0, 4'd9,  1, 0, 1);
    vecs[30] = mk(0, 16'h0200, 0, 4'd9,  1, 0, 1);
    vecs[31] = mk(1, 16'h0200, 0, 4'd0,  0, 0, 0);
    vecs[32] = mk(0, 16'h0014, 0, 4'd2,  1, 0, 1);
    // Single requester is re-granted after the GAP cycle.
    vecs[33] = mk(0, 16'h0004, 1, 4'd2,  0, 0, 1);
    vecs[34] = mk(0, 16'h0004, 0, 4'd2,  1, 0, 1);
    vecs[35] = mk(0, 16'h0000, 0, 4'd2,  0, 0, 1);
    vecs[36] = mk(0, 16'h0000, 0, 4'd2,  0, 0, 0);
    vecs[37] = mk(1, 16'h0000, 0, 4'd0,  0, 0, 0);

    for (int i = 0; i < 38; i++) begin
      rst  = vecs[i].rst;
      req  = vecs[i].req;
      done = vecs[i].done;
      tick();
      chk($sformatf("vec%0d", i), vecs[i].idx, vecs[i].valid, vecs[i].to, vecs[i].busy);
    end

    // Full sweep with every master requesting and done held high.
    rst  = 1'b0;
    req  = 16'hFFFF;
    done = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      logic [3:0] e;
      e = 4'(k);
      tick();
      chk($sformatf("sweep_own%0d", k), e, 1'b1, 1'b0, 1'b1);
      tick();
      chk($sformatf("sweep_gap%0d", k), e, 1'b0, 1'b0, 1'b1);
    end
    req  = '0;
    done = 1'b0;
    tick();
    chk("sweep_idle", 4'd0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
